wb_project_mux: RTL and testbench

- Wishbone slave controller that shares the management-SoC Wishbone bus among NPROJ user sub-projects of the multi-project user area.
- Decodes the address into a project slot and forwards one transaction at a time to that slot.
- Guards every forwarded transaction with an ack timeout.
- Hosts control registers that pick which project owns the IO mux and which projects are enabled.
- Sits directly below the top-level user wrapper, between the wrapper's Wishbone port and the per-project instances.

---
 rtl/wb_project_mux_pkg.sv | 23 ++
 rtl/wb_project_mux_if.sv | 21 ++
 rtl/wb_project_mux_regs.sv | 74 +++++++
 rtl/wb_project_mux.sv | 163 ++++++++++++++++
 tb/tb_wb_project_mux.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_project_mux_pkg.sv
// Shared types and constants for the multi-project Wishbone mux and its register file.
package wb_project_mux_pkg;

  typedef enum logic [1:0] {
    IDLE_ST = 2'd0,
    FWD_ST  = 2'd1,
    RESP_ST = 2'd2
  } mux_state_e;

  localparam logic [1:0]  REG_CTRL     = 2'd0;
  localparam logic [1:0]  REG_EN       = 2'd1;
  localparam logic [1:0]  REG_STAT     = 2'd2;
  localparam logic [1:0]  REG_ID       = 2'd3;
  localparam logic [3:0]  CTRL_REGION  = 4'hF;
  localparam logic [31:0] ID_VALUE     = 32'h4953_4849;
  localparam logic [31:0] ERR_DATA_DEF = 32'hFFFF_FFFF;

  // Expands the four Wishbone byte selects into a 32-bit write mask.
  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/wb_project_mux_if.sv
// Host-side Wishbone bus between the user wrapper and the project mux.
interface wb_project_mux_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_project_mux_regs.sv
// Control/status registers of the project mux: project select, enables, sticky timeout status.
module wb_mux_regs
  import wb_project_mux_pkg::*;
#(
  parameter int NPROJ = 4,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [1:0]       off,
  input  logic [31:0]      wdata,
  input  logic [3:0]       sel,
  input  logic             to_evt,
  input  logic [SEL_W-1:0] to_idx,
  output logic [SEL_W-1:0] proj_sel,
  output logic [NPROJ-1:0] proj_en,
  output logic             sticky,
  output logic [31:0]      rdata
);

  logic [SEL_W-1:0] proj_sel_r;
  logic [NPROJ-1:0] proj_en_r;
  logic             sticky_r;
  logic [3:0]       last_idx_r;
  logic [31:0]      mask_s;
  logic [31:0]      ctrl_nxt_s;
  logic [31:0]      en_nxt_s;
  logic             unused_s;

  assign mask_s     = byte_mask(sel);
  assign ctrl_nxt_s = (32'(proj_sel_r) & ~mask_s) | (wdata & mask_s);
  assign en_nxt_s   = (32'(proj_en_r) & ~mask_s) | (wdata & mask_s);
  assign unused_s   = ^{ctrl_nxt_s[31:SEL_W], en_nxt_s[31:NPROJ]};

  // Register updates; a timeout capture outranks a same-cycle W1C.
  always_ff @(posedge clk) begin
    if (rst) begin
      proj_sel_r <= {SEL_W{1'b0}};
      proj_en_r  <= {NPROJ{1'b0}};
      sticky_r   <= 1'b0;
      last_idx_r <= 4'd0;
    end else begin
      if (wr_en && (off == REG_CTRL)) proj_sel_r <= ctrl_nxt_s[SEL_W-1:0];
      if (wr_en && (off == REG_EN))   proj_en_r  <= en_nxt_s[NPROJ-1:0];
      if (to_evt) begin
        sticky_r   <= 1'b1;
        last_idx_r <= 4'(to_idx);
      end else if (wr_en && (off == REG_STAT) && sel[0] && wdata[0]) begin
        sticky_r <= 1'b0;
      end
    end
  end

  // Read mux; unimplemented bits read as zero.
  always_comb begin
    rdata = 32'd0;
    case (off)
      REG_CTRL: rdata[SEL_W-1:0] = proj_sel_r;
      REG_EN:   rdata[NPROJ-1:0] = proj_en_r;
      REG_STAT: begin
        rdata[0]    = sticky_r;
        rdata[11:8] = last_idx_r;
      end
      REG_ID:   rdata = ID_VALUE;
      default:  rdata = 32'd0;
    endcase
  end

  assign proj_sel = proj_sel_r;
  assign proj_en  = proj_en_r;
  assign sticky   = sticky_r;

endmodule

// File: rtl/wb_project_mux.sv
// Shares the management Wishbone bus among NPROJ project slots, one transaction at a time,
// with an ack timeout on every forwarded access and a small control block at region 0xF.
module wb_project_mux
  import wb_project_mux_pkg::*;
#(
  parameter int          NPROJ    = 4,
  parameter int          SEL_W    = 4,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  wb_project_mux_if.slave       wbs,
  output logic [NPROJ-1:0]      p_cyc_o,
  output logic [NPROJ-1:0]      p_stb_o,
  output logic                  p_we_o,
  output logic [3:0]            p_sel_o,
  output logic [31:0]           p_adr_o,
  output logic [31:0]           p_dat_o,
  input  logic [NPROJ-1:0]      p_ack_i,
  input  logic [NPROJ*32-1:0]   p_dat_i,
  output logic [SEL_W-1:0]      proj_sel_o,
  output logic [NPROJ-1:0]      proj_en_o,
  output logic                  irq_o
);

  localparam logic [3:0]  NPROJ_4 = 4'(NPROJ);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  mux_state_e       state_r, state_s;
  logic [15:0]      cnt_r, cnt_s;
  logic [31:0]      adr_r, dat_r, odat_r, resp_s, reg_rdata_s, slot_rdata_s;
  logic [3:0]       sel_r, region_s;
  logic             we_r, ack_r, lat_s, ctrl_wr_s, to_evt_s;
  logic             is_ctrl_s, is_slot_s, slot_en_s, ack_hit_s;
  logic [SEL_W-1:0] idx_r;
  logic [NPROJ-1:0] hit_r, hit_s, hit_nxt_s, fwd_r;

  assign region_s  = wbs.wbs_adr_i[23:20];
  assign is_ctrl_s = (region_s == CTRL_REGION);
  assign is_slot_s = (region_s < NPROJ_4);
  assign slot_en_s = |(hit_s & proj_en_o);
  assign ack_hit_s = |(p_ack_i & hit_r);

  // One-hot slot decode of the incoming address and read-data steering from the latched slot.
  always_comb begin
    hit_s        = {NPROJ{1'b0}};
    slot_rdata_s = 32'd0;
    for (int k = 0; k < NPROJ; k++) begin
      hit_s[k] = is_slot_s && (region_s == 4'(k));
      if (hit_r[k]) slot_rdata_s = slot_rdata_s | p_dat_i[32*k +: 32];
      else          slot_rdata_s = slot_rdata_s;
    end
  end

  wb_mux_regs #(.NPROJ(NPROJ), .SEL_W(SEL_W)) u_regs (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .wr_en    (ctrl_wr_s),
    .off      (wbs.wbs_adr_i[3:2]),
    .wdata    (wbs.wbs_dat_i),
    .sel      (wbs.wbs_sel_i),
    .to_evt   (to_evt_s),
    .to_idx   (idx_r),
    .proj_sel (proj_sel_o),
    .proj_en  (proj_en_o),
    .sticky   (irq_o),
    .rdata    (reg_rdata_s)
  );

  // Next-state logic; a host abort outranks the slot ack, which outranks the timeout.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    resp_s    = 32'd0;
    lat_s     = 1'b0;
    ctrl_wr_s = 1'b0;
    to_evt_s  = 1'b0;
    case (state_r)
      IDLE_ST: begin
        if (wbs.wbs_cyc_i && wbs.wbs_stb_i) begin
          lat_s = 1'b1;
          cnt_s = 16'd0;
          if (is_ctrl_s) begin
            ctrl_wr_s = wbs.wbs_we_i;
            resp_s    = reg_rdata_s;
            state_s   = RESP_ST;
          end else if (slot_en_s) begin
            state_s = FWD_ST;
          end else begin
            resp_s  = ERR_DATA;
            state_s = RESP_ST;
          end
        end else begin
          state_s = IDLE_ST;
        end
      end
      FWD_ST: begin
        if (!wbs.wbs_cyc_i) begin
          state_s = IDLE_ST;
        end else if (ack_hit_s) begin
          resp_s  = slot_rdata_s;
          state_s = RESP_ST;
        end else if (cnt_r == TO_LAST) begin
          resp_s   = ERR_DATA;
          to_evt_s = 1'b1;
          state_s  = RESP_ST;
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      RESP_ST: state_s = IDLE_ST;
      default: state_s = IDLE_ST;
    endcase
    if (lat_s) hit_nxt_s = hit_s;
    else       hit_nxt_s = hit_r;
  end

  // FSM state register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_r <= IDLE_ST;
    else          state_r <= state_s;
  end

  // Latched request, timeout counter and registered bus outputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt_r  <= 16'd0;
      adr_r  <= 32'd0;
      dat_r  <= 32'd0;
      sel_r  <= 4'd0;
      we_r   <= 1'b0;
      idx_r  <= {SEL_W{1'b0}};
      hit_r  <= {NPROJ{1'b0}};
      fwd_r  <= {NPROJ{1'b0}};
      ack_r  <= 1'b0;
      odat_r <= 32'd0;
    end else begin
      cnt_r <= cnt_s;
      if (lat_s) begin
        adr_r <= wbs.wbs_adr_i;
        dat_r <= wbs.wbs_dat_i;
        sel_r <= wbs.wbs_sel_i;
        we_r  <= wbs.wbs_we_i;
        idx_r <= SEL_W'(region_s);
        hit_r <= hit_s;
      end
      fwd_r  <= (state_s == FWD_ST) ? hit_nxt_s : {NPROJ{1'b0}};
      ack_r  <= (state_s == RESP_ST);
      odat_r <= resp_s;
    end
  end

  assign wbs.wbs_ack_o = ack_r;
  assign wbs.wbs_dat_o = odat_r;
  assign p_cyc_o       = fwd_r;
  assign p_stb_o       = fwd_r;
  assign p_we_o        = we_r;
  assign p_sel_o       = sel_r;
  assign p_adr_o       = adr_r;
  assign p_dat_o       = dat_r;

endmodule

// File: tb/tb_wb_project_mux.sv
// Self-checking bench for wb_project_mux: directed vector table, abort/reset sequences and
// randomized traffic against a register/slot reference model.
module tb_wb_project_mux;
  localparam int          NPROJ   = 4;
  localparam int          SEL_W   = 4;
  localparam int          TIMEOUT = 8;
  localparam logic [31:0] ERRD    = 32'hFFFF_FFFF;
  localparam logic [31:0] IDV     = 32'h4953_4849;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_project_mux_if bus();
  logic [NPROJ-1:0]    p_cyc, p_stb, p_ack, proj_en, stray;
  logic                p_we, irq;
  logic [3:0]          p_sel;
  logic [31:0]         p_adr, p_dat;
  logic [NPROJ*32-1:0] p_dat_in;
  logic [SEL_W-1:0]    proj_sel;

  wb_project_mux #(.NPROJ(NPROJ), .SEL_W(SEL_W), .TIMEOUT(TIMEOUT), .ERR_DATA(ERRD)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs(bus),
    .p_cyc_o(p_cyc), .p_stb_o(p_stb), .p_we_o(p_we), .p_sel_o(p_sel),
    .p_adr_o(p_adr), .p_dat_o(p_dat), .p_ack_i(p_ack), .p_dat_i(p_dat_in),
    .proj_sel_o(proj_sel), .proj_en_o(proj_en), .irq_o(irq)
  );

  // Slot models: slot k acks in the slot_dly-th cycle of its strobe (0 = never).
  int          slot_dly;
  int          slot_age [NPROJ];
  logic [31:0] slot_data [NPROJ];

  always @(posedge clk)
    for (int k = 0; k < NPROJ; k++) slot_age[k] <= p_stb[k] ? slot_age[k] + 1 : 0;

  always_comb begin
    p_ack    = stray;
    p_dat_in = {NPROJ*32{1'b0}};
    for (int k = 0; k < NPROJ; k++) begin
      if (p_stb[k] && slot_dly > 0 && slot_age[k] == slot_dly - 1) p_ack[k] = 1'b1;
      p_dat_in[32*k +: 32] = slot_data[k];
    end
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic set_slots(input int d, input logic [31:0] sd, input logic [31:0] adr);
    slot_dly = d;
    for (int k = 0; k < NPROJ; k++) slot_data[k] = (adr[23:20] == 4'(k)) ? sd : ~sd;
  endtask

  // One host transaction; reports latency, strobe cycles, bad strobes and one-cycle ack.
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rd, output int cyc,
                      output int stb_cyc, output int bad, output logic ack_ok);
    logic [3:0] r;
    logic [3:0] m;
    r = adr[23:20];
    m = (r < 4'd4) ? (4'b0001 << r) : 4'b0000;
    rd = 32'd0; cyc = 0; stb_cyc = 0; bad = 0;
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_adr_i = adr; bus.wbs_dat_i = dat; bus.wbs_sel_i = sel;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); @(negedge clk);
      cyc++;
      if (p_stb != 4'b0000) begin
        stb_cyc++;
        if ((p_stb & ~m) != 4'b0000 || p_cyc != p_stb || p_adr != adr || p_we != we) bad++;
      end
      if (bus.wbs_ack_o) begin
        rd = bus.wbs_dat_o;
        break;
      end
    end
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    @(posedge clk); @(negedge clk);
    ack_ok = !bus.wbs_ack_o && (bus.wbs_dat_o == 32'd0);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr, dat;
    logic [3:0]  sel;
    int          dly;
    logic [31:0] sdat;
    logic [3:0]  stray;
    logic [31:0] exp_dat;
    int          exp_cyc;
    logic        exp_irq;
    logic [3:0]  exp_en;
  } vec_t;

  function automatic vec_t mk(logic we, logic [31:0] adr, logic [31:0] dat, logic [3:0] sel,
                              int dly, logic [31:0] sdat, logic [3:0] st, logic [31:0] ed,
                              int ec, logic ei, logic [3:0] ee);
    vec_t v;
    v.we = we; v.adr = adr; v.dat = dat; v.sel = sel; v.dly = dly; v.sdat = sdat;
    v.stray = st; v.exp_dat = ed; v.exp_cyc = ec; v.exp_irq = ei; v.exp_en = ee;
    return v;
  endfunction

  vec_t        vq[$];
  logic [31:0] rd;
  int          cyc, stb_cyc, bad;
  logic        ack_ok, seen;
  logic [3:0]  m_en, m_sel, m_last;
  logic        m_sticky;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = 32'd0; bus.wbs_dat_i = 32'd0;
    stray = 4'b0000;
    set_slots(0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ack/dat", {31'd0, bus.wbs_ack_o} | bus.wbs_dat_o, 32'd0);
    chk("reset p_cyc/stb", {24'd0, p_cyc, p_stb}, 32'd0);
    chk("reset p_bus", p_adr | p_dat | {27'd0, p_we, p_sel}, 32'd0);
    chk("reset regs", {23'd0, irq, proj_en, proj_sel}, 32'd0);
    rst = 1'b0;

    //           we    adr           dat           sel   dly sdat          stray   exp_dat       cyc irq en
    vq.push_back(mk(1'b1, 32'h00F0_0004, 32'h0000_0005, 4'hF, 0, 32'd0,        4'b0000, 32'd0,        1, 1'b0, 4'b0101));
    vq.push_back(mk(1'b0, 32'h00F0_0004, 32'd0,         4'hF, 0, 32'd0,        4'b0000, 32'h0000_0005, 1, 1'b0, 4'b0101));
    vq.push_back(mk(1'b0, 32'h00F0_000C, 32'd0,         4'hF, 0, 32'd0,        4'b0000, IDV,          1, 1'b0, 4'b0101));
    vq.push_back(mk(1'b1, 32'h00F0_0000, 32'hFFFF_FF02, 4'hE, 0, 32'd0,        4'b0000, 32'd0,        1, 1'b0, 4'b0101));
    vq.push_back(mk(1'b0, 32'h00F0_0000, 32'd0,         4'hF, 0, 32'd0,        4'b0000, 32'h0,        1, 1'b0, 4'b0101));
    vq.push_back(mk(1'b1, 32'h00F0_0000, 32'hFFFF_FF0A, 4'h1, 0, 32'd0,        4'b0000, 32'd0,        1, 1'b0, 4'b0101));
    vq.push_back(mk(1'b0, 32'h00F0_0000, 32'd0,         4'hF, 0, 32'd0,        4'b0000, 32'h0000_000A, 1, 1'b0, 4'b0101));
    vq.push_back(mk(1'b0, 32'h3020_0000, 32'd0,         4'hF, 3, 32'h1234_5678, 4'b0000, 32'h1234_5678, 4, 1'b0, 4'b0101));
    vq.push_back(mk(1'b0, 32'h0010_0000, 32'd0,         4'hF, 1, 32'h5555_0000, 4'b0000, ERRD,         1, 1'b0, 4'b0101));
    vq.push_back(mk(1'b0, 32'h0070_0000, 32'd0,         4'hF, 1, 32'h5555_0000, 4'b0000, ERRD,         1, 1'b0, 4'b0101));
    vq.push_back(mk(1'b1, 32'h00F0_0004, 32'h0000_000D, 4'h1, 0, 32'd0,        4'b0000, 32'd0,        1, 1'b0, 4'b1101));
    vq.push_back(mk(1'b0, 32'h0030_0000, 32'd0,         4'hF, 0, 32'd0,        4'b0111, ERRD,         9, 1'b1, 4'b1101));
    vq.push_back(mk(1'b0, 32'h00F0_0008, 32'd0,         4'hF, 0, 32'd0,        4'b0000, 32'h0000_0301, 1, 1'b1, 4'b1101));
    vq.push_back(mk(1'b1, 32'h00F0_0008, 32'h0000_0001, 4'h1, 0, 32'd0,        4'b0000, 32'd0,        1, 1'b0, 4'b1101));
    vq.push_back(mk(1'b0, 32'h00F0_0008, 32'd0,         4'hF, 0, 32'd0,        4'b0000, 32'h0000_0300, 1, 1'b0, 4'b1101));
    vq.push_back(mk(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'h3, 1, 32'h0BAD_0000, 4'b0000, 32'd0,        2, 1'b0, 4'b1101));
    vq.push_back(mk(1'b0, 32'h0000_0000, 32'd0,         4'hF, 8, 32'hCAFE_0001, 4'b0000, 32'hCAFE_0001, 9, 1'b0, 4'b1101));
    vq.push_back(mk(1'b0, 32'h0000_0000, 32'd0,         4'hF, 7, 32'hCAFE_0002, 4'b0000, 32'hCAFE_0002, 8, 1'b0, 4'b1101));

    for (int i = 0; i < vq.size(); i++) begin
      set_slots(vq[i].dly, vq[i].sdat, vq[i].adr);
      stray = vq[i].stray;
      xfer(vq[i].we, vq[i].adr, vq[i].dat, vq[i].sel, rd, cyc, stb_cyc, bad, ack_ok);
      stray = 4'b0000;
      if (!vq[i].we) chk($sformatf("v%0d data", i), rd, vq[i].exp_dat);
      chk($sformatf("v%0d latency", i), 32'(cyc), 32'(vq[i].exp_cyc));
      chk($sformatf("v%0d stb cycles", i), 32'(stb_cyc), 32'((vq[i].exp_cyc > 1) ? vq[i].exp_cyc - 1 : 0));
      chk($sformatf("v%0d bad stb", i), 32'(bad), 32'd0);
      chk($sformatf("v%0d ack one cycle", i), {31'd0, ack_ok}, 32'd1);
      chk($sformatf("v%0d irq", i), {31'd0, irq}, {31'd0, vq[i].exp_irq});
      chk($sformatf("v%0d proj_en", i), {28'd0, proj_en}, {28'd0, vq[i].exp_en});
    end

    // Host abort two cycles into a forward, then a control write.
    xfer(1'b1, 32'h00F0_0004, 32'h0000_000F, 4'h1, rd, cyc, stb_cyc, bad, ack_ok);
    chk("abort en setup", {28'd0, proj_en}, 32'h0000_000F);
    set_slots(0, 32'd0, 32'd0);
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0; bus.wbs_adr_i = 32'h0000_0000;
    @(posedge clk); @(negedge clk);
    chk("abort fwd cyc", {28'd0, p_cyc}, 32'h0000_0001);
    @(posedge clk); @(negedge clk);
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("abort p_cyc drop", {24'd0, p_cyc, p_stb}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.wbs_ack_o) seen = 1'b1;
      @(negedge clk);
    end
    chk("abort stray ack", {31'd0, seen}, 32'd0);
    xfer(1'b1, 32'h00F0_0000, 32'h0000_0003, 4'h1, rd, cyc, stb_cyc, bad, ack_ok);
    chk("abort ctrl latency", 32'(cyc), 32'd1);
    chk("abort ctrl sel", {28'd0, proj_sel}, 32'h0000_0003);

    // Randomized traffic against the reference model.
    m_en = 4'hF; m_sel = 4'h3; m_sticky = 1'b0; m_last = 4'h3;
    for (int n = 0; n < 80; n++) begin
      int          kind, k, dly, exp_cyc;
      logic        we;
      logic [31:0] adr, dat, sdat, exp_dat;
      logic [3:0]  sel;
      logic [1:0]  off;
      kind = $urandom_range(0, 9);
      we   = 1'($urandom_range(0, 1));
      dat  = $urandom;
      sdat = $urandom;
      sel  = 4'($urandom_range(0, 15));
      dly  = $urandom_range(0, 10);
      adr  = $urandom;
      exp_cyc = 1;
      exp_dat = ERRD;
      if (kind < 4) begin
        off = 2'($urandom_range(0, 3));
        adr[23:20] = 4'hF;
        adr[3:2]   = off;
        case (off)
          2'd0:    exp_dat = {28'd0, m_sel};
          2'd1:    exp_dat = {28'd0, m_en};
          2'd2:    exp_dat = {20'd0, m_last, 7'd0, m_sticky};
          default: exp_dat = IDV;
        endcase
        if (we && sel[0]) begin
          if (off == 2'd0) m_sel = dat[3:0];
          if (off == 2'd1) m_en = dat[3:0];
          if (off == 2'd2 && dat[0]) m_sticky = 1'b0;
        end
      end else if (kind < 9) begin
        k = $urandom_range(0, NPROJ - 1);
        adr[23:20] = 4'(k);
        if (m_en[k]) begin
          if (dly == 0 || dly > TIMEOUT) begin
            exp_cyc = TIMEOUT + 1;
            m_sticky = 1'b1;
            m_last = 4'(k);
          end else begin
            exp_cyc = dly + 1;
            exp_dat = sdat;
          end
        end
      end else begin
        adr[23:20] = 4'($urandom_range(4, 14));
      end
      set_slots(dly, sdat, adr);
      xfer(we, adr, dat, sel, rd, cyc, stb_cyc, bad, ack_ok);
      if (!we) chk($sformatf("r%0d data", n), rd, exp_dat);
      chk($sformatf("r%0d latency", n), 32'(cyc), 32'(exp_cyc));
      chk($sformatf("r%0d stb cycles", n), 32'(stb_cyc), 32'(exp_cyc - 1));
      chk($sformatf("r%0d bad stb", n), 32'(bad), 32'd0);
      chk($sformatf("r%0d ack one cycle", n), {31'd0, ack_ok}, 32'd1);
      chk($sformatf("r%0d regs", n), {23'd0, irq, proj_en, proj_sel}, {23'd0, m_sticky, m_en, m_sel});
    end

    // Reset during a forward; a late slot ack must not produce a host ack.
    xfer(1'b1, 32'h00F0_0004, 32'h0000_000F, 4'h1, rd, cyc, stb_cyc, bad, ack_ok);
    set_slots(0, 32'd0, 32'h0010_0000);
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0; bus.wbs_adr_i = 32'h0010_0000;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("rst fwd cyc", {28'd0, p_cyc}, 32'h0000_0002);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rst ack/dat", {31'd0, bus.wbs_ack_o} | bus.wbs_dat_o, 32'd0);
    chk("rst p_cyc/stb", {24'd0, p_cyc, p_stb}, 32'd0);
    chk("rst p_bus", p_adr | p_dat | {27'd0, p_we, p_sel}, 32'd0);
    chk("rst regs", {23'd0, irq, proj_en, proj_sel}, 32'd0);
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    stray = 4'b0010;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.wbs_ack_o) seen = 1'b1;
    end
    stray = 4'b0000;
    chk("rst late ack", {31'd0, seen}, 32'd0);
    xfer(1'b0, 32'h00F0_000C, 32'd0, 4'hF, rd, cyc, stb_cyc, bad, ack_ok);
    chk("rst id data", rd, IDV);
    chk("rst id latency", 32'(cyc), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
